// File: rtl/ysyx_22050710_inst_sram_if.sv
// Instruction-SRAM read bus between the fetch stage (master) and the
// instruction memory (slave): read request, byte address, registered data.
interface ysyx_22050710_inst_sram_if #(
  parameter int unsigned ADDR_WD = 32,
  parameter int unsigned DATA_WD = 64
);
  logic               ren;
  logic [ADDR_WD-1:0] addr;
  logic [DATA_WD-1:0] rdata;

  modport master (output ren, output addr, input rdata);
  modport slave  (input ren, input addr, output rdata);
endinterface

// File: rtl/ysyx_22050710_inst_sram.sv
// Synchronous-read instruction memory. After reset it fills every word with
// FILL_DATA, then serves 64-bit word reads (1-cycle latency) and byte-strobed
// loader writes, flagging out-of-range accesses with a sticky error bit.
module ysyx_22050710_inst_sram #(
  parameter int unsigned                 SRAM_ADDR_WD = 32,
  parameter int unsigned                 SRAM_DATA_WD = 64,
  parameter int unsigned                 DEPTH_LOG2   = 12,
  parameter logic [SRAM_ADDR_WD-1:0]     BASE_ADDR    = 'h8000_0000,
  parameter logic [SRAM_DATA_WD-1:0]     FILL_DATA    = '0,
  parameter logic [SRAM_DATA_WD-1:0]     ERR_DATA     = 64'h0010_0073_0010_0073
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  ysyx_22050710_inst_sram_if.slave  inst_sram,
  input  logic                      i_load_wen,
  input  logic [SRAM_ADDR_WD-1:0]   i_load_addr,
  input  logic [SRAM_DATA_WD-1:0]   i_load_wdata,
  input  logic [SRAM_DATA_WD/8-1:0] i_load_wstrb,
  output logic                      o_init_done,
  output logic                      o_oor_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned NBYTE = SRAM_DATA_WD / 8;
  localparam logic [DEPTH_LOG2-1:0] LAST_IDX = '1;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [DEPTH_LOG2-1:0]   fill_idx;

  logic [SRAM_DATA_WD-1:0] mem [DEPTH];
  logic [SRAM_DATA_WD-1:0] rdata_q;

  logic [SRAM_ADDR_WD-1:0] rd_off;
  logic [SRAM_ADDR_WD-1:0] ld_off;
  logic                    rd_in;
  logic                    ld_in;
  logic [DEPTH_LOG2-1:0]   rd_idx;
  logic [DEPTH_LOG2-1:0]   ld_idx;
  logic                    ld_hit;
  logic [SRAM_DATA_WD-1:0] wr_word;

  // Address decode for both ports: offset from BASE_ADDR, range check, word index
  always_comb begin
    rd_off = inst_sram.addr - BASE_ADDR;
    ld_off = i_load_addr - BASE_ADDR;
    rd_in  = (rd_off >> (DEPTH_LOG2 + 3)) == '0;
    ld_in  = (ld_off >> (DEPTH_LOG2 + 3)) == '0;
    rd_idx = rd_off[DEPTH_LOG2+2:3];
    ld_idx = ld_off[DEPTH_LOG2+2:3];
    ld_hit = (state == ST_RUN) && i_load_wen && ld_in;
  end

  // Merged write word: old contents with the strobed bytes replaced; also
  // forwarded to a same-index read so collisions behave write-first
  always_comb begin
    wr_word = mem[ld_idx];
    for (int unsigned k = 0; k < NBYTE; k++) begin
      if (i_load_wstrb[k]) begin
        wr_word[8*k +: 8] = i_load_wdata[8*k +: 8];
      end
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: leave INIT once the last word has been filled
  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && fill_idx == LAST_IDX) begin
      state_nxt = ST_RUN;
    end
  end

  // Fill counter, registered read data and sticky range-error flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fill_idx  <= '0;
      rdata_q   <= '0;
      o_oor_err <= 1'b0;
    end else if (state == ST_INIT) begin
      fill_idx <= fill_idx + 1'b1;
      if (inst_sram.ren) begin
        rdata_q <= ERR_DATA;
      end
    end else begin
      if (inst_sram.ren) begin
        if (!rd_in) begin
          rdata_q <= ERR_DATA;
        end else if (ld_hit && ld_idx == rd_idx) begin
          rdata_q <= wr_word;
        end else begin
          rdata_q <= mem[rd_idx];
        end
      end
      if ((inst_sram.ren && !rd_in) || (i_load_wen && !ld_in)) begin
        o_oor_err <= 1'b1;
      end
    end
  end

  // Array write port: fill during INIT, strobed loader writes in RUN
  always_ff @(posedge i_clk) begin
    if (state == ST_INIT) begin
      mem[fill_idx] <= FILL_DATA;
    end else if (ld_hit) begin
      mem[ld_idx] <= wr_word;
    end
  end

  assign inst_sram.rdata = rdata_q;
  assign o_init_done     = (state == ST_RUN);

endmodule

// File: tb/tb_ysyx_22050710_inst_sram.sv
// Bench for ysyx_22050710_inst_sram with a 16-word array: directed scenarios
// with literal expectations, then randomized traffic against a word-array model.
module tb_ysyx_22050710_inst_sram;

  localparam logic [63:0] ERR  = 64'h0010_0073_0010_0073;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          NW   = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_wen = 1'b0;
  logic [31:0] load_addr = '0;
  logic [63:0] load_wdata = '0;
  logic [7:0]  load_wstrb = '0;
  logic        init_done;
  logic        oor_err;

  int n_tests = 0;
  int n_fail  = 0;

  ysyx_22050710_inst_sram_if #(.ADDR_WD(32), .DATA_WD(64)) bus ();

  ysyx_22050710_inst_sram #(.DEPTH_LOG2(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .inst_sram    (bus.slave),
    .i_load_wen   (load_wen),
    .i_load_addr  (load_addr),
    .i_load_wdata (load_wdata),
    .i_load_wstrb (load_wstrb),
    .o_init_done  (init_done),
    .o_oor_err    (oor_err)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [63:0] m_mem [NW];
  logic [63:0] m_rdata = '0;
  logic        m_oor = 1'b0;
  int          m_edges = 0;   // rising edges seen since reset release

  always @(negedge rst_n) begin
    m_edges = 0;
    m_rdata = '0;
    m_oor   = 1'b0;
  end

  always @(posedge clk) begin
    logic [31:0] off;
    logic [63:0] w;
    if (rst_n) begin
      if (m_edges < NW) begin
        if (bus.ren) m_rdata = ERR;
        m_mem[m_edges] = '0;
      end else begin
        if (load_wen) begin
          off = load_addr - BASE;
          if (off < 32'd128) begin
            w = m_mem[off / 8];
            for (int b = 0; b < 8; b++)
              if (load_wstrb[b]) w[8*b +: 8] = load_wdata[8*b +: 8];
            m_mem[off / 8] = w;
          end else begin
            m_oor = 1'b1;
          end
        end
        if (bus.ren) begin
          off = bus.addr - BASE;
          if (off < 32'd128) begin
            m_rdata = m_mem[off / 8];
          end else begin
            m_rdata = ERR;
            m_oor   = 1'b1;
          end
        end
      end
      m_edges = m_edges + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model comparison on every falling edge
  always @(negedge clk) begin
    check("m_rdata", bus.rdata, m_rdata);
    check("m_init_done", {63'd0, init_done}, {63'd0, m_edges >= NW});
    check("m_oor", {63'd0, oor_err}, {63'd0, m_oor});
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic rd(input logic [31:0] a);
    bus.ren  = 1'b1;
    bus.addr = a;
    step();
    bus.ren  = 1'b0;
  endtask

  task automatic ld(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    load_wen   = 1'b1;
    load_addr  = a;
    load_wdata = d;
    load_wstrb = s;
    step();
    load_wen   = 1'b0;
  endtask

  // Runs n fill edges after release; a read is issued on the first one
  task automatic fill_edges(input int n);
    for (int i = 1; i <= n; i++) begin
      if (i == 1) begin
        bus.ren  = 1'b1;
        bus.addr = BASE + 32'h20;
      end
      step();
      bus.ren = 1'b0;
      check("init_done_edge", {63'd0, init_done}, {63'd0, i >= NW});
      if (i == 1) begin
        check("init_rd", bus.rdata, ERR);
        check("init_oor", {63'd0, oor_err}, 64'd0);
      end
    end
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    #1;
    check("rst_rdata", bus.rdata, 64'd0);
    check("rst_init_done", {63'd0, init_done}, 64'd0);
    check("rst_oor", {63'd0, oor_err}, 64'd0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    bus.ren  = 1'b0;
    bus.addr = '0;
    step();
    step();
    rst_n = 1'b1;

    // Init then first read of the last word
    fill_edges(NW);
    rd(32'h8000_0078);
    check("init_word", bus.rdata, 64'd0);
    check("init_word_oor", {63'd0, oor_err}, 64'd0);

    // Full write then read of the same word via the upper half address
    ld(32'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF);
    rd(32'h8000_000C);
    check("full_write", bus.rdata, 64'h1122_3344_5566_7788);

    // Partial strobe, then hold with ren low
    ld(32'h8000_0008, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F);
    rd(32'h8000_0008);
    check("partial", bus.rdata, 64'h1122_3344_BBBB_BBBB);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold", bus.rdata, 64'h1122_3344_BBBB_BBBB);
    end

    // Same-cycle write and read of one word
    load_wen   = 1'b1;
    load_addr  = 32'h8000_0010;
    load_wdata = 64'hDEAD_BEEF_CAFE_F00D;
    load_wstrb = 8'hFF;
    rd(32'h8000_0010);
    load_wen   = 1'b0;
    check("collision", bus.rdata, 64'hDEAD_BEEF_CAFE_F00D);

    // Out-of-range reads; sticky flag
    rd(32'h8000_0080);
    check("oor_rdata", bus.rdata, ERR);
    check("oor_flag", {63'd0, oor_err}, 64'd1);
    rd(32'h8000_0010);
    check("oor_sticky_rd", bus.rdata, 64'hDEAD_BEEF_CAFE_F00D);
    check("oor_sticky", {63'd0, oor_err}, 64'd1);
    rd(32'h7FFF_FFF8);
    check("below_base", bus.rdata, ERR);

    // Reset clears flag and data; then reset again five edges into the fill
    assert_reset();
    fill_edges(5);
    assert_reset();
    fill_edges(NW);

    // Fresh fill erased earlier writes; write-only strobe zero is a no-op
    ld(32'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    rd(32'h8000_0010);
    check("refill_zero", bus.rdata, 64'd0);
    check("strobe0_oor", {63'd0, oor_err}, 64'd0);

    // Randomized traffic, mostly in range, with forced collisions
    for (int c = 0; c < 400; c++) begin
      a = BASE + ($urandom_range(0, 127));
      if ($urandom_range(0, 31) == 0) a = $urandom;
      bus.ren  = ($urandom_range(0, 3) != 0);
      bus.addr = a;
      load_wen = ($urandom_range(0, 2) == 0);
      a = BASE + ($urandom_range(0, 127));
      if ($urandom_range(0, 4) == 0) a = bus.addr;
      if ($urandom_range(0, 47) == 0) a = BASE + 32'h80 + $urandom_range(0, 255);
      load_addr  = a;
      load_wdata = {$urandom, $urandom};
      load_wstrb = 8'($urandom_range(0, 255));
      step();
    end
    bus.ren  = 1'b0;
    load_wen = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22050710_inst_sram.md
# ysyx_22050710_inst_sram

Responder side of the fetch stage's instruction-SRAM interface (`ren` / `addr` → `rdata`). It is a synchronous-read instruction memory of `2^DEPTH_LOG2` words, each `SRAM_DATA_WD` bits wide. Each accepted read returns the whole aligned 64-bit word one cycle later, and the fetch stage selects the 32-bit half with `pc[2]`. After reset the block runs a fill sequence over the whole array. It also provides a byte-strobed load port for the program loader and flags out-of-range accesses.

## Interface
Parameters:
- `SRAM_ADDR_WD`, 32, width of the byte address.
- `SRAM_DATA_WD`, 64, word width (multiple of 8).
- `DEPTH_LOG2`, 12, log2 of the word count (default 4096 words, 32 KiB).
- `BASE_ADDR`, 32'h8000_0000, byte address of word 0.
- `FILL_DATA`, 64'h0, value written to every word during init.
- `ERR_DATA`, 64'h0010_0073_0010_0073, returned for out-of-range reads or reads during init (ebreak pair).

Ports:
- `i_clk`, in, 1, clock; all state changes on the rising edge.
- `i_rst_n`, in, 1, reset, asynchronous, active-low.
- `i_inst_sram_ren`, in, 1, read request.
- `i_inst_sram_addr`, in, `SRAM_ADDR_WD`, read byte address; bits [2:0] ignored.
- `o_inst_sram_rdata`, out, `SRAM_DATA_WD`, registered read data.
- `i_load_wen`, in, 1, loader write request.
- `i_load_addr`, in, `SRAM_ADDR_WD`, loader byte address; bits [2:0] ignored.
- `i_load_wdata`, in, `SRAM_DATA_WD`, loader write data.
- `i_load_wstrb`, in, `SRAM_DATA_WD/8`, byte enables; bit k covers bits [8k+7:8k].
- `o_init_done`, out, 1, high once the fill completes; the top holds the core in reset until it is high.
- `o_oor_err`, out, 1, sticky out-of-range flag.

## Operation
- **Address decode**
  - `off = addr - BASE_ADDR`, computed modulo 2^`SRAM_ADDR_WD`.
  - In range iff `off >> (DEPTH_LOG2+3) == 0`.
  - Word index = `off[DEPTH_LOG2+2:3]`.
- **FSM state INIT** (entered on reset)
  - An index counter runs 0 → `DEPTH-1`, writing `FILL_DATA` to one word per cycle.
  - The load port is ignored.
  - A read with `ren`=1 returns `ERR_DATA` and does not set `o_oor_err`.
  - When the counter writes `DEPTH-1`, the FSM moves to RUN.
- **FSM state RUN** (terminal until reset)
  - In-range read: the next `rdata` is the word at the index.
  - Out-of-range read: the next `rdata` is `ERR_DATA`, and `o_oor_err` is set.
- **Load write in RUN**
  - In-range: only the bytes whose strobe bit is set are updated.
  - Out-of-range: no array change, and `o_oor_err` is set.
  - `wstrb`=0 with `wen`=1 is a legal no-op; the range check still applies.
- **Read/write collision** (same cycle, same index, both in range): write-first. The returned `rdata` is the old word with the strobed bytes replaced by `wdata`.
- **Read data hold:** `ren`=0 leaves `o_inst_sram_rdata` unchanged.
- **`o_oor_err`** is cleared only by reset.

## Timing
- **Reset values:** `o_inst_sram_rdata`=0, `o_init_done`=0, `o_oor_err`=0, FSM=INIT, counter=0. Array contents are not reset; the fill defines them.
- **Init duration:** the first rising edge after `i_rst_n` deasserts writes index 0. `o_init_done` goes high after edge number `DEPTH` and stays high until reset.
- **Read latency:** 1 cycle. `addr`/`ren` sampled at edge N produce `rdata` valid after edge N. The interface has no backpressure and no stall; a new read is accepted every cycle.
- **Write latency:** a load write sampled at edge N is visible to reads sampled at edge N (collision rule) and later.
- **`o_oor_err` timing:** it rises after the same edge that samples the offending access.
- **Reset mid-operation:** asserting `i_rst_n` low asynchronously clears all outputs and returns the FSM to INIT with counter=0. The fill restarts in full; a partial fill is never resumed.

## Test plan
Bench parameters: `DEPTH_LOG2`=4 (16 words, range 0x8000_0000 to 0x8000_007F), defaults otherwise.
- **Init:** release reset → `o_init_done` is 0 for 15 edges and 1 after the 16th edge. Then read 0x8000_0078 → `rdata`=0 and `o_oor_err`=0.
- **Full write:** load 0x8000_0008, data 0x1122_3344_5566_7788, wstrb 0xFF. Next cycle read 0x8000_000C → `rdata`=0x1122_3344_5566_7788 one cycle later.
- **Partial strobe and hold:** load the same word with 0xAAAA_AAAA_BBBB_BBBB, wstrb 0x0F. Read → 0x1122_3344_BBBB_BBBB. Then `ren`=0 for 3 cycles → `rdata` is unchanged throughout.
- **Collision:** in one cycle, load 0x8000_0010 with full strobe and data 0xDEAD_BEEF_CAFE_F00D, and read 0x8000_0010 → next `rdata`=0xDEAD_BEEF_CAFE_F00D.
- **Out of range:** read 0x8000_0080 → `rdata`=0x0010_0073_0010_0073 and `o_oor_err`=1 next cycle. The flag stays 1 through later in-range reads. A read of 0x7FFF_FFF8 also returns `ERR_DATA`.
- **Reset mid-init:** assert `i_rst_n` low 5 cycles into the fill → `rdata`, `o_init_done` and `o_oor_err` are 0 immediately. On release a full 16-cycle fill precedes `o_init_done`=1, and an INIT-phase read returns `ERR_DATA` with `o_oor_err` staying 0.
